transmit_mux: RTL and testbench

Round-robin scheduler that shares one serial `transmit` instance among N byte-stream requesters. Each grant produces a burst on the line: one channel-header byte, then up to BURST data bytes from the granted requester. It sits between the requester-side logic and `transmit`. A remote `receive` can demultiplex the stream by header byte.

---
 rtl/transmit_mux.sv | 142 ++++++++++++++
 tb/tb_transmit_mux.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transmit_mux.sv
// transmit_mux: round-robin scheduler sharing one serial transmitter among N
// byte-stream requesters. Each grant emits a channel-header byte
// {4'hF, channel} followed by up to BURST data bytes from the granted channel.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   req_stb  per-requester byte-valid
//   req_dat  per-requester byte, channel 0 in the LSBs
//   req_rdy  per-requester byte-accepted strobe
//   tx_stb   byte valid toward the transmitter
//   tx_dat   byte toward the transmitter (8'h00 when tx_stb is low)
//   tx_rdy   transmitter accepts the byte this cycle
module transmit_mux #(
  parameter int unsigned N     = 4,
  parameter int unsigned BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_stb,
  input  logic [8*N-1:0]   req_dat,
  output logic [N-1:0]     req_rdy,
  output logic             tx_stb,
  output logic [7:0]       tx_dat,
  input  logic             tx_rdy
);

  localparam int unsigned GW = (N > 2) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HEAD = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam logic [7:0]    LAST_CNT = 8'(BURST - 1);
  localparam logic [GW-1:0] LAST_CH  = GW'(N - 1);
  localparam logic [GW:0]   N_EXT    = (GW + 1)'(N);

  logic [1:0]    state, state_n;
  logic [GW-1:0] gnt, gnt_n;
  logic [GW-1:0] ptr, ptr_n;
  logic [7:0]    cnt, cnt_n;

  logic [GW-1:0] pick;
  logic          pick_found;
  logic [GW:0]   scan;
  logic [GW-1:0] ptr_after;
  logic          sel_stb;
  logic [7:0]    sel_dat;

  // First requesting channel at or above ptr, wrapping from N-1 to 0.
  always_comb begin
    pick       = ptr;
    pick_found = 1'b0;
    scan       = '0;
    for (int k = 0; k < int'(N); k++) begin
      scan = {1'b0, ptr} + (GW + 1)'(k);
      if (scan >= N_EXT) begin
        scan = scan - N_EXT;
      end
      if (!pick_found && req_stb[scan[GW-1:0]]) begin
        pick       = scan[GW-1:0];
        pick_found = 1'b1;
      end
    end
  end

  // Priority start for the next evaluation once the current burst ends.
  always_comb begin
    ptr_after = (gnt == LAST_CH) ? '0 : gnt + GW'(1);
  end

  // Granted channel's strobe and byte, passed straight through in DATA.
  always_comb begin
    sel_stb = req_stb[gnt];
    sel_dat = req_dat[{gnt, 3'b000} +: 8];
  end

  // State and burst bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state and line outputs. Outputs depend on the state registers and,
  // in DATA only, combinationally on the granted requester and tx_rdy.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    ptr_n   = ptr;
    cnt_n   = cnt;
    tx_stb  = 1'b0;
    tx_dat  = 8'h00;
    req_rdy = '0;

    case (state)
      IDLE: begin
        if (|req_stb) begin
          gnt_n   = pick;
          cnt_n   = '0;
          state_n = HEAD;
        end
      end

      HEAD: begin
        tx_stb = 1'b1;
        tx_dat = {4'hF, 4'(gnt)};
        if (tx_rdy) begin
          state_n = DATA;
        end
      end

      DATA: begin
        tx_stb       = sel_stb;
        tx_dat       = sel_stb ? sel_dat : 8'h00;
        // Accept strobe only when a byte is actually on offer.
        req_rdy[gnt] = sel_stb & tx_rdy;
        // Burst ends on a dropped strobe or on the BURST-th transfer.
        if (!sel_stb || (tx_rdy && (cnt == LAST_CNT))) begin
          state_n = IDLE;
          cnt_n   = '0;
          ptr_n   = ptr_after;
        end else if (tx_rdy) begin
          cnt_n = cnt + 8'd1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_transmit_mux.sv
// tb_transmit_mux: randomized and directed stimulus for transmit_mux with a
// queue-based scoreboard. Each requester owns a byte queue; when queues are
// loaded, a round-robin reference model predicts the full line byte stream.
// A separate monitor pops the prediction on every tx handshake.
module tb_transmit_mux;

  localparam int N     = 4;
  localparam int BURST = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_stb;
  logic [8*N-1:0]   req_dat;
  logic [N-1:0]     req_rdy;
  logic             tx_stb;
  logic [7:0]       tx_dat;
  logic             tx_rdy;

  logic [7:0] chq [N][$];
  logic [7:0] expq[$];
  int         mptr;
  int         rdy_cnt[N];
  int         n_cmp;
  int         n_err;
  bit         mon_en;

  transmit_mux #(.N(N), .BURST(BURST)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_stb (req_stb),
    .req_dat (req_dat),
    .req_rdy (req_rdy),
    .tx_stb  (tx_stb),
    .tx_dat  (tx_dat),
    .tx_rdy  (tx_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += chq[i].size();
    return s;
  endfunction

  // Reference: predict the line stream for everything now queued, assuming
  // every non-empty requester keeps its strobe up until drained.
  task automatic model_push();
    int rem[N];
    int pos[N];
    int total;
    int c;
    int nb;
    bit found;
    total = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = chq[i].size();
      pos[i] = 0;
      total += rem[i];
    end
    while (total > 0) begin
      c = 0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && rem[(mptr + k) % N] > 0) begin
          c = (mptr + k) % N;
          found = 1'b1;
        end
      end
      expq.push_back(8'hF0 | 8'(c));
      nb = (rem[c] < BURST) ? rem[c] : BURST;
      for (int b = 0; b < nb; b++) expq.push_back(chq[c][pos[c] + b]);
      pos[c] += nb;
      rem[c] -= nb;
      total  -= nb;
      mptr = (c + 1) % N;
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_stb[i]         = (chq[i].size() > 0);
      req_dat[8*i +: 8]  = (chq[i].size() > 0) ? chq[i][0] : 8'h00;
    end
  endtask

  // One clock of requester/transmitter behaviour, entered and left at posedge+1.
  task automatic step(input bit rdy, input bit ck, input bit es, input logic [7:0] ed);
    logic [N-1:0] acc;
    tx_rdy = rdy;
    @(negedge clk);
    acc = req_rdy & req_stb;
    for (int i = 0; i < N; i++) rdy_cnt[i] += int'(req_rdy[i]);
    if (ck) begin
      chk("held_stb", 32'(tx_stb), 32'(es));
      chk("held_dat", 32'(tx_dat), 32'(ed));
      chk("held_rdy", 32'(req_rdy), 32'(0));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && chq[i].size() > 0) void'(chq[i].pop_front());
    drive_reqs();
  endtask

  task automatic run_phase(input int pct);
    int g = 0;
    while ((pending() != 0 || expq.size() != 0) && g < 3000) begin
      step(($urandom_range(99, 0) < 32'(pct)), 1'b0, 1'b0, 8'h00);
      g++;
    end
    chk("phase_drained", 32'(pending()) + 32'(expq.size()), 32'(0));
    step(1'($urandom_range(1, 0)), 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  // Monitor: line scoreboard plus per-cycle output rules.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (mon_en && !rst) begin
      if (!tx_stb) chk("idle_dat_zero", 32'(tx_dat), 32'(0));
      chk("rdy_onehot", 32'($countones(req_rdy) <= 1), 32'(1));
      for (int i = 0; i < N; i++) begin
        if (req_rdy[i]) begin
          chk("rdy_handshake", 32'({tx_stb, tx_rdy, req_stb[i]}), 32'(3'b111));
          chk("rdy_dat", 32'(tx_dat), 32'(req_dat[8*i +: 8]));
        end
      end
      if (tx_stb && tx_rdy) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: got %02h, expected no byte at %0t", tx_dat, $time);
        end else begin
          e = expq.pop_front();
          chk("line_byte", 32'(tx_dat), 32'(e));
        end
      end
    end
  end

  initial begin
    int g;
    int n;
    int pct;
    n_cmp   = 0;
    n_err   = 0;
    mptr    = 0;
    mon_en  = 1'b0;
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    rst     = 1'b1;
    req_stb = '1;
    req_dat = 32'($urandom);
    tx_rdy  = 1'b1;

    // Reset holds outputs quiet even with every request and tx_rdy high.
    @(negedge clk);
    chk("rst_tx_stb", 32'(tx_stb), 32'(0));
    chk("rst_tx_dat", 32'(tx_dat), 32'(0));
    chk("rst_req_rdy", 32'(req_rdy), 32'(0));
    @(posedge clk);
    #1;
    drive_reqs();
    tx_rdy = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Round robin: all four channels request together.
    for (int i = 0; i < N; i++) chq[i].push_back(8'hA0 + 8'(i));
    model_push();
    drive_reqs();
    run_phase(100);

    // Single byte with latency checks.
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    chq[0].push_back(8'h55);
    model_push();
    drive_reqs();
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'hF0);
    run_phase(100);
    chk("ch0_rdy_pulses", 32'(rdy_cnt[0]), 32'(1));

    // Burst split: six bytes from ch2.
    for (int b = 0; b < 6; b++) chq[2].push_back(8'h10 + 8'(b));
    model_push();
    drive_reqs();
    run_phase(70);

    // Fairness: ch1 and ch3 stream continuously.
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    for (int b = 0; b < 16; b++) begin
      chq[1].push_back(8'($urandom));
      chq[3].push_back(8'($urandom));
    end
    model_push();
    drive_reqs();
    run_phase(80);
    chk("fair_ch0_none", 32'(rdy_cnt[0]), 32'(0));
    chk("fair_ch2_none", 32'(rdy_cnt[2]), 32'(0));
    chk("fair_ch1_all", 32'(rdy_cnt[1]), 32'(16));
    chk("fair_ch3_all", 32'(rdy_cnt[3]), 32'(16));

    // Back-pressure in HEAD and then in DATA.
    chq[1].push_back(8'hC1);
    chq[1].push_back(8'hC2);
    chq[1].push_back(8'hC3);
    model_push();
    drive_reqs();
    step(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (1000) step(1'b0, 1'b1, 1'b1, 8'hF1);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (1000) step(1'b0, 1'b1, 1'b1, 8'hC1);
    run_phase(60);

    // Header followed by zero data bytes: strobe drops while in HEAD.
    g = mptr;
    expq.push_back(8'hF0 | 8'(g));
    mptr = (g + 1) % N;
    req_stb[g] = 1'b1;
    req_dat[8*g +: 8] = 8'h99;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'hF0 | 8'(g));
    run_phase(100);

    // Randomized phases.
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3, 0) != 0) begin
          n = int'($urandom_range(9, 1));
          for (int b = 0; b < n; b++) chq[i].push_back(8'($urandom));
        end
      end
      pct = int'($urandom_range(100, 25));
      model_push();
      drive_reqs();
      run_phase(pct);
    end

    // Reset in the middle of a ch3 burst.
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    for (int b = 0; b < 10; b++) chq[3].push_back(8'h60 + 8'(b));
    model_push();
    drive_reqs();
    g = 0;
    while (rdy_cnt[3] < 2 && g < 500) begin
      step(1'b1, 1'b0, 1'b0, 8'h00);
      g++;
    end
    chk("midburst_reached", 32'(rdy_cnt[3]), 32'(2));
    tx_rdy = 1'b0;
    #1;
    chk("midburst_stb", 32'(tx_stb), 32'(1));
    rst = 1'b1;
    #1;
    chk("async_rst_stb", 32'(tx_stb), 32'(0));
    chk("async_rst_dat", 32'(tx_dat), 32'(0));
    chk("async_rst_rdy", 32'(req_rdy), 32'(0));
    for (int i = 0; i < N; i++) chq[i].delete();
    expq.delete();
    mptr = 0;
    chq[1].push_back(8'h31);
    chq[1].push_back(8'h32);
    chq[3].push_back(8'h33);
    model_push();
    drive_reqs();
    @(posedge clk);
    #1;
    chk("rst_held_stb", 32'(tx_stb), 32'(0));
    rst = 1'b0;
    run_phase(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
